clk_monitor: RTL and testbench
==============================

Name: clk_monitor

Overview:
- Synthesizable receive-side counterpart of the bench clock generators: observes an asynchronous monitored clock `mon_clk` using the system clock `clk`.
- Reports each measured period in `clk` cycles, tracks min/max, accumulates fixed-size windows, and flags a stopped or out-of-range clock.
- Sits beside clock-generation logic as a health monitor readable by a testbench or CSR block.

Parameters:
- CNT_W, 16, width of the period counter and of min/max/last outputs.
- TIMEOUT, 1024, `clk` cycles without a detected `mon_clk` rise before `stopped` asserts; must be < 2**CNT_W.
- WIN_LOG2, 3, periods per accumulation window = 2**WIN_LOG2.
- EXP_MIN, 8, smallest legal period in `clk` cycles.
- EXP_MAX, 12, largest legal period in `clk` cycles.

Ports:
- clk, in, 1, system clock; all logic is on its rising edge.
- rst, in, 1, synchronous active-high reset.
- en, in, 1, monitor enable.
- mon_clk, in, 1, monitored clock; asynchronous to `clk`.
- last_period, out, CNT_W, most recent measured period.
- period_valid, out, 1, one-cycle pulse when `last_period` updates.
- min_period, out, CNT_W, smallest period since arming.
- max_period, out, CNT_W, largest period since arming.
- win_sum, out, CNT_W+WIN_LOG2, sum of the last completed window.
- win_done, out, 1, one-cycle pulse when `win_sum` updates.
- stopped, out, 1, level; `mon_clk` has not toggled for TIMEOUT cycles.
- out_of_range, out, 1, sticky; some period fell outside [EXP_MIN, EXP_MAX].

Behaviour:
- Clock and reset: one clock (`clk`); reset is synchronous and active-high (`rst`).
- Reset values:
  - state = IDLE.
  - last_period = 0, min_period = all ones, max_period = 0, win_sum = 0.
  - period_valid, win_done, stopped and out_of_range = 0.
  - Synchronizer flops = 0.
  - Reset mid-measurement discards everything in the same cycle.
- Input sync: 2-flop synchronizer plus a third flop. `rise` = sync2 & ~sync3. Detection latency is 2–3 `clk` cycles from a `mon_clk` edge. A `mon_clk` that is high for less than one `clk` period may be missed; this is legal behaviour and must not be flagged.
- State machine: IDLE, ARM, MEAS, STOP.
  - IDLE: counters frozen, outputs hold their values. `en`=1 moves to ARM and clears min/max (to reset values), out_of_range, stopped, the window accumulator and the window count.
  - ARM: wait for `rise`. On `rise` go to MEAS with cnt=1. No period is reported. ARM does not time out.
  - MEAS: cnt increments each cycle and saturates at all ones.
    - On `rise`: last_period = cnt, period_valid pulses the next cycle, min/max update, range check runs, window accumulates, then cnt=1.
    - If cnt reaches TIMEOUT with no `rise`: go to STOP, stopped=1, partial window discarded (accumulator and count cleared).
  - STOP: on `rise` go to MEAS with cnt=1, stopped=0, no period reported. The first period after a restart is reported on the second edge.
  - Any state with `en`=0: go to IDLE next cycle. `stopped` clears. Other outputs hold. Valid pulses never fire in IDLE.
- Period definition: the number of `clk` cycles between consecutive detected rises. Example: a `mon_clk` period of exactly 10 `clk` cycles gives 10.
- Simultaneous rise and timeout (cnt == TIMEOUT on a rise cycle): the rise wins. The period is reported and the state stays MEAS.
- Window:
  - Adder width is CNT_W+WIN_LOG2, so it never overflows.
  - On the 2**WIN_LOG2-th period: win_sum = acc + period, win_done pulses together with period_valid, acc = 0.
- Range check: period < EXP_MIN or > EXP_MAX sets out_of_range. It clears only on reset or on an IDLE→ARM transition.
- Latency: period_valid is asserted exactly one `clk` after the `rise` cycle.

Decomposition:
- Package clk_monitor_pkg:
  - state enum `clk_mon_state_t` {IDLE, ARM, MEAS, STOP}.
  - Default-width localparams.
  - Helper function computing the window-sum width.
- Sub-module sync_rise_detect:
  - Parameter STAGES=2.
  - Ports: clk, rst, async_in, rise.
  - Reused for other asynchronous inputs.

Test Plan:
- Reset and arm: mon_clk period 10 `clk`, `en`=1 → first period_valid on the second detected rise; last_period=10 and min=max=10 every pulse; after 8 periods win_done pulses with win_sum=80.
- Jitter: mon_clk periods alternating 9/11 → min_period=9, max_period=11, win_sum=80, out_of_range=0.
- Out of range: one period of 13 within a stream of 10 → out_of_range=1 from the cycle after that period_valid, still 1 after further 10-cycle periods; toggling `en` 0→1 clears it.
- Stop/restart: hold mon_clk low → stopped=1 exactly TIMEOUT cycles after the last rise with no win_done; resume at period 10 → stopped=0 on the first rise, next period_valid reports 10, window restarts from zero.
- Boundary: TIMEOUT=16, mon_clk period exactly 16 → every edge reports 16, stopped never asserts; period 17 → stopped asserts.
- Disruption: `en`=0 mid-window → IDLE next cycle with no pulses; assert `rst` during MEAS → all outputs at reset values the following cycle.

Source files
------------

// File: rtl/clk_monitor_pkg.sv
// Shared types and default parameters for the clock monitor.
// The window-sum width helper keeps the top-level and any reader consistent.
package clk_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2,
    STOP = 2'd3
  } clk_mon_state_t;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_TIMEOUT  = 1024;
  localparam int DEF_WIN_LOG2 = 3;
  localparam int DEF_EXP_MIN  = 8;
  localparam int DEF_EXP_MAX  = 12;

  // Wide enough to hold 2**win_log2 periods of cnt_w bits without overflow.
  function automatic int win_sum_w(input int cnt_w, input int win_log2);
    return cnt_w + win_log2;
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-flop synchronizer for an asynchronous level, followed by a one-cycle
// rising-edge pulse generated in the clk domain.
module sync_rise_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] sync_p0;
  logic              prev_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      prev_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[STAGES-2:0], async_in};
      prev_p1 <= sync_p0[STAGES-1];
    end
  end

  assign rise = sync_p0[STAGES-1] & ~prev_p1;

endmodule

// File: rtl/clk_monitor.sv
// Measures the period of an asynchronous clock in clk cycles, tracks min/max,
// sums fixed-size windows and flags stopped or out-of-range behaviour.
module clk_monitor
  import clk_monitor_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int WIN_LOG2 = DEF_WIN_LOG2,
  parameter int EXP_MIN  = DEF_EXP_MIN,
  parameter int EXP_MAX  = DEF_EXP_MAX
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic                                   mon_clk,
  output logic [CNT_W-1:0]                       last_period,
  output logic                                   period_valid,
  output logic [CNT_W-1:0]                       min_period,
  output logic [CNT_W-1:0]                       max_period,
  output logic [win_sum_w(CNT_W, WIN_LOG2)-1:0]  win_sum,
  output logic                                   win_done,
  output logic                                   stopped,
  output logic                                   out_of_range
);

  localparam int               SUM_W     = win_sum_w(CNT_W, WIN_LOG2);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] EXP_MIN_C = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0] EXP_MAX_C = CNT_W'(EXP_MAX);

  clk_mon_state_t       state;
  logic [CNT_W-1:0]     cnt;
  logic [SUM_W-1:0]     acc;
  logic [WIN_LOG2-1:0]  win_cnt;
  logic                 rise;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic in_range(input logic [CNT_W-1:0] v);
    return (v >= EXP_MIN_C) && (v <= EXP_MAX_C);
  endfunction

  sync_rise_detect #(.STAGES(2)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (mon_clk),
    .rise     (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      win_cnt      <= '0;
      last_period  <= '0;
      period_valid <= 1'b0;
      min_period   <= '1;
      max_period   <= '0;
      win_sum      <= '0;
      win_done     <= 1'b0;
      stopped      <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      win_done     <= 1'b0;
      if (!en) begin
        state   <= IDLE;
        stopped <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state        <= ARM;
            min_period   <= '1;
            max_period   <= '0;
            out_of_range <= 1'b0;
            stopped      <= 1'b0;
            acc          <= '0;
            win_cnt      <= '0;
          end
          ARM: begin
            if (rise) begin
              state <= MEAS;
              cnt   <= CNT_W'(1);
            end
          end
          MEAS: begin
            // A rise on the timeout cycle still counts as a valid period.
            if (rise) begin
              last_period  <= cnt;
              period_valid <= 1'b1;
              if (cnt < min_period) min_period <= cnt;
              if (cnt > max_period) max_period <= cnt;
              if (!in_range(cnt)) out_of_range <= 1'b1;
              if (win_cnt == '1) begin
                win_sum  <= acc + SUM_W'(cnt);
                win_done <= 1'b1;
                acc      <= '0;
              end else begin
                acc <= acc + SUM_W'(cnt);
              end
              win_cnt <= win_cnt + 1'b1;
              cnt     <= CNT_W'(1);
            end else if (cnt == TIMEOUT_C) begin
              state   <= STOP;
              stopped <= 1'b1;
              acc     <= '0;
              win_cnt <= '0;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          STOP: begin
            if (rise) begin
              state   <= MEAS;
              cnt     <= CNT_W'(1);
              stopped <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_monitor.sv
// Randomized and directed bench for clk_monitor; expected periods, windows,
// min/max and range flags come from a cycle-timestamp model of mon_clk edges.
module tb_clk_monitor;
  import clk_monitor_pkg::*;

  localparam int CNT_W    = 16;
  localparam int TIMEOUT  = 16;
  localparam int WIN_LOG2 = 3;
  localparam int EXP_MIN  = 8;
  localparam int EXP_MAX  = 12;
  localparam int SUM_W    = CNT_W + WIN_LOG2;
  localparam int WIN_N    = 1 << WIN_LOG2;
  localparam int ONES     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, en, mon_clk;
  logic [CNT_W-1:0] last_period, min_period, max_period;
  logic [SUM_W-1:0] win_sum;
  logic             period_valid, win_done, stopped, out_of_range;

  clk_monitor #(
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .WIN_LOG2(WIN_LOG2),
    .EXP_MIN(EXP_MIN), .EXP_MAX(EXP_MAX)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mon_clk(mon_clk),
    .last_period(last_period), .period_valid(period_valid),
    .min_period(min_period), .max_period(max_period),
    .win_sum(win_sum), .win_done(win_done),
    .stopped(stopped), .out_of_range(out_of_range)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit saw_stop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint expv);
    n_chk++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  // Reference model: periods are differences between edge timestamps.
  typedef struct {
    int p; bit win; longint sum; int mn; int mx; bit oor;
  } exp_t;
  exp_t q[$];

  bit     en_m = 0;
  bit     have_prev = 0;
  int     prev_cyc = 0;
  int     mn = ONES, mx = 0;
  bit     oor = 0;
  longint acc = 0;
  int     wcnt = 0;

  task automatic model_enable();
    en_m = 1; have_prev = 0; mn = ONES; mx = 0; oor = 0; acc = 0; wcnt = 0;
  endtask

  task automatic model_disable();
    en_m = 0; have_prev = 0;
  endtask

  task automatic model_rise(input int t);
    exp_t e;
    int g;
    if (!en_m) return;
    if (!have_prev) begin
      have_prev = 1; prev_cyc = t; return;
    end
    g = t - prev_cyc;
    prev_cyc = t;
    if (g > TIMEOUT) begin
      acc = 0; wcnt = 0; return;
    end
    if (g < mn) mn = g;
    if (g > mx) mx = g;
    if (g < EXP_MIN || g > EXP_MAX) oor = 1;
    acc += g; wcnt++;
    e.p = g; e.mn = mn; e.mx = mx; e.oor = oor; e.win = 0; e.sum = 0;
    if (wcnt == WIN_N) begin
      e.win = 1; e.sum = acc; acc = 0; wcnt = 0;
    end
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (stopped) saw_stop = 1;
    if (period_valid) begin
      if (q.size() == 0) check("pv_unexpected", period_valid, 0);
      else begin
        e = q.pop_front();
        check("last_period", last_period, e.p);
        check("min_period", min_period, e.mn);
        check("max_period", max_period, e.mx);
        check("out_of_range", out_of_range, e.oor);
        check("win_done", win_done, e.win);
        if (e.win) check("win_sum", win_sum, e.sum);
      end
    end else if (win_done) begin
      check("wd_without_pv", win_done, 0);
    end
  end

  task automatic drive_period(input int p);
    int hi;
    hi = p / 2;
    mon_clk = 1'b1;
    model_rise(cyc);
    repeat (hi) @(negedge clk);
    mon_clk = 1'b0;
    repeat (p - hi) @(negedge clk);
  endtask

  task automatic toggle_en();
    en = 1'b0;
    model_disable();
    repeat (2) @(negedge clk);
    en = 1'b1;
    model_enable();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_last"}, last_period, 0);
    check({tag, "_min"}, min_period, ONES);
    check({tag, "_max"}, max_period, 0);
    check({tag, "_wsum"}, win_sum, 0);
    check({tag, "_pv"}, period_valid, 0);
    check({tag, "_wd"}, win_done, 0);
    check({tag, "_stop"}, stopped, 0);
    check({tag, "_oor"}, out_of_range, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mon_clk = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    en = 1'b1;
    model_enable();
    repeat (3) @(negedge clk);

    // Steady period 10: two full windows.
    repeat (17) drive_period(10);

    // Alternating 9/11 jitter.
    toggle_en();
    for (int i = 0; i < 17; i++) drive_period((i % 2) ? 11 : 9);
    check("jit_min", min_period, 9);
    check("jit_max", max_period, 11);
    check("jit_oor", out_of_range, 0);

    // One out-of-range period, sticky until re-arm.
    toggle_en();
    repeat (4) drive_period(10);
    drive_period(13);
    repeat (4) drive_period(10);
    check("oor_sticky", out_of_range, 1);
    toggle_en();
    check("oor_cleared", out_of_range, 0);
    check("rearm_min", min_period, ONES);
    check("rearm_max", max_period, 0);

    // Stop and restart.
    repeat (3) drive_period(10);
    mon_clk = 1'b1;
    model_rise(cyc);
    @(negedge clk);
    mon_clk = 1'b0;
    repeat (TIMEOUT + 1) @(negedge clk);
    check("stop_early", stopped, 0);
    @(negedge clk);
    check("stop_set", stopped, 1);
    repeat (10) @(negedge clk);
    mon_clk = 1'b1;
    model_rise(cyc);
    repeat (2) @(negedge clk);
    check("stop_hold", stopped, 1);
    @(negedge clk);
    check("stop_clear", stopped, 0);
    mon_clk = 1'b0;
    repeat (7) @(negedge clk);
    repeat (9) drive_period(10);

    // Period equal to the timeout never stops; one cycle longer does.
    saw_stop = 0;
    repeat (9) drive_period(TIMEOUT);
    check("bound_no_stop", saw_stop, 0);
    repeat (2) drive_period(TIMEOUT + 1);
    check("bound_stop", saw_stop, 1);

    // Disable mid-window: no pulses while idle.
    toggle_en();
    repeat (4) drive_period(10);
    en = 1'b0;
    model_disable();
    repeat (5) drive_period(10);
    check("idle_stopped", stopped, 0);
    en = 1'b1;
    model_enable();
    repeat (3) @(negedge clk);

    // Reset while measuring.
    repeat (3) drive_period(10);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    model_enable();
    repeat (3) @(negedge clk);
    repeat (10) drive_period(10);

    // Random periods, including out-of-range and timeouts.
    for (int i = 0; i < 60; i++) drive_period($urandom_range(6, TIMEOUT + 2));

    repeat (6) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
